// File: rtl/led_serial_shifter_if.sv
// Parallel-load handshake and serial LED chain signals for led_serial_shifter.
// The master side supplies the LED word; the slave side is the shifter itself.
interface led_serial_shifter_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] data_in;
  logic             en_in;
  logic             rdy;
  logic             led_clk;
  logic             led_oe;
  logic             led_out;

  modport master (
    output data_in, en_in,
    input  rdy, led_clk, led_oe, led_out
  );

  modport slave (
    input  data_in, en_in,
    output rdy, led_clk, led_oe, led_out
  );
endinterface

// File: rtl/led_serial_shifter.sv
// Shifts a parallel LED word MSB-first into the external LED chain, blanking it while shifting.
// Optional LED_REFRESH_EN macro: periodically re-sends the last word after REFRESH_CYCLES idle cycles.
module led_serial_shifter #(
  parameter int WIDTH          = 24,
  parameter int CLK_DIV        = 1,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  led_serial_shifter_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, SETTLE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n, bit_nxt;
  logic [DW-1:0]    div_cnt, div_cnt_n;
  logic             rdy_q, rdy_n;
  logic             led_clk_q, led_clk_n;
  logic             led_oe_q, led_oe_n;
  logic             led_out_q, led_out_n;
  logic             div_done;
  logic             start;
  logic [WIDTH-1:0] start_word;

`ifdef LED_REFRESH_EN
  localparam int IW = $clog2(REFRESH_CYCLES + 1);
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic          armed, armed_n;
`endif

  assign div_done    = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_nxt     = bit_cnt - 1'b1;
  assign bus.rdy     = rdy_q;
  assign bus.led_clk = led_clk_q;
  assign bus.led_oe  = led_oe_q;
  assign bus.led_out = led_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      rdy_q     <= 1'b1;
      led_clk_q <= 1'b0;
      led_oe_q  <= 1'b1;
      led_out_q <= 1'b0;
`ifdef LED_REFRESH_EN
      idle_cnt  <= '0;
      armed     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      bit_cnt   <= bit_cnt_n;
      div_cnt   <= div_cnt_n;
      rdy_q     <= rdy_n;
      led_clk_q <= led_clk_n;
      led_oe_q  <= led_oe_n;
      led_out_q <= led_out_n;
`ifdef LED_REFRESH_EN
      idle_cnt  <= idle_cnt_n;
      armed     <= armed_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    shadow_n   = shadow;
    bit_cnt_n  = bit_cnt;
    div_cnt_n  = div_cnt;
    rdy_n      = rdy_q;
    led_clk_n  = led_clk_q;
    led_oe_n   = led_oe_q;
    led_out_n  = led_out_q;
    start      = 1'b0;
    start_word = bus.data_in;
`ifdef LED_REFRESH_EN
    idle_cnt_n = '0;
    armed_n    = armed;
`endif

    case (state)
      IDLE: begin
        div_cnt_n = '0;
        if (bus.en_in) begin
          start = 1'b1;
`ifdef LED_REFRESH_EN
        end else if (armed && idle_cnt == IW'(REFRESH_CYCLES - 1)) begin
          // A refresh replays the stored word; DATA_IN is not sampled
          start      = 1'b1;
          start_word = shadow;
        end else if (armed) begin
          idle_cnt_n = idle_cnt + 1'b1;
`endif
        end
      end

      SHIFT_LO: begin
        if (div_done) begin
          div_cnt_n = '0;
          led_clk_n = 1'b1;
          state_n   = SHIFT_HI;
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      SHIFT_HI: begin
        // Data only moves on the falling LED_CLK edge so it is stable for the whole low phase
        if (div_done) begin
          div_cnt_n = '0;
          led_clk_n = 1'b0;
          if (bit_cnt != '0) begin
            bit_cnt_n = bit_nxt;
            led_out_n = shadow[bit_nxt];
            state_n   = SHIFT_LO;
          end else begin
            led_out_n = 1'b0;
            state_n   = SETTLE;
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      SETTLE: begin
        if (div_done) begin
          div_cnt_n = '0;
          led_oe_n  = 1'b0;
          rdy_n     = 1'b1;
          state_n   = IDLE;
`ifdef LED_REFRESH_EN
          armed_n   = 1'b1;
`endif
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    if (start) begin
      shadow_n  = start_word;
      bit_cnt_n = BW'(WIDTH - 1);
      div_cnt_n = '0;
      rdy_n     = 1'b0;
      led_oe_n  = 1'b1;
      led_out_n = start_word[WIDTH-1];
      state_n   = SHIFT_LO;
    end
  end

endmodule
